uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmitter
// Purpose: serialiser state encoding, frame constants and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Integer divide; the caller must keep the result at 2 or more.
  function automatic int clks_per_bit(input int sys_clk_freq, input int baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered flags and overflow pulse
// Purpose: byte queue between the CPU write path and the serialiser.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write request and data (ignored while full)
//   pop, pop_data      read request and head-of-queue data (ignored while empty)
//   full, empty, count registered occupancy status
//   overflow           one-cycle pulse after a push was dropped because full
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  do_push;
  logic                  do_pop;

  // Gating uses the registered flags, so a pop in the same cycle never
  // makes room for a push that arrives while full.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      full     <= (count_next == DEPTH_CNT);
      empty    <= (count_next == '0);
      overflow <= push && full;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART 8N1 transmitter, LSB first
// Purpose: queue CPU byte writes and serialise them onto the tx pin.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_data      byte push request
//   full, empty, count  FIFO status (registered)
//   overflow            one-cycle pulse when a push was dropped
//   busy                serialiser is framing (not IDLE)
//   tx                  serial line, idle high
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic                busy,
  output logic                tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shift, shift_next;
  logic              tx_q, tx_next;
  logic              pop;
  logic [7:0]        head;
  logic              baud_wrap;

  sync_fifo #(
    .WIDTH     (8),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_en),
    .push_data(wr_data),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE);
  assign tx        = tx_q;

  always_comb begin
    state_next = state;
    baud_next  = baud_wrap ? '0 : baud_cnt + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = shift[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_idx == BIT_LAST) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_idx + 1'b1;
            tx_next  = shift[bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued bytes leave
        // with no idle gap between frames.
        if (baud_wrap) begin
          if (!empty) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is a flop with asynchronous set so the line goes idle the moment
  // reset asserts, even mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx_q     <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int SYS   = 400;
  localparam int BAUD  = 100;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [DL2:0] count;
  logic       overflow;
  logic       busy;
  logic       tx;

  uart_tx_fifo #(
    .SYS_CLK_FREQ(SYS),
    .BAUD_RATE   (BAUD),
    .DEPTH_LOG2  (DL2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue for the FIFO plus the edge at which the
  // current frame's stop bit ends; the line level follows from position.
  logic [7:0] q[$];
  logic [7:0] cur_byte = 8'h00;
  int         e = 0;
  int         frame_end = 0;
  logic       exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic exp_busy();
    return e < frame_end;
  endfunction

  function automatic logic exp_tx();
    int p;
    int b;
    if (e >= frame_end) return 1'b1;
    p = e - (frame_end - FRAME);
    b = p / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur_byte[b-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic we, input logic [7:0] d);
    int  pre;
    logic full_pre;
    e++;
    pre = q.size();
    full_pre = (pre == DEPTH);
    if (e >= frame_end && pre > 0) begin
      cur_byte  = q.pop_front();
      frame_end = e + FRAME;
    end
    if (we && !full_pre) q.push_back(d);
    exp_ovf = we && full_pre;
  endtask

  task automatic check_all();
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("busy", 32'(busy), 32'(exp_busy()));
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    model_edge(we, d);
    #1;
    wr_en = 1'b0;
    check_all();
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx), 32'd1);
    chk("rst_async_count", 32'(count), 32'd0);
    q.delete();
    frame_end = 0;
    exp_ovf   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e++;
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] pat;
    int         busy_cycles;
    int         peak;
    int         ovf_pulses;
    int         full_seen;

    // 1: reset, then the line must stay idle
    #2;
    hold_reset(5);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);

    // 2: single byte 0xA5, line sampled at each bit start
    pat = 10'b1101001010;
    step(1'b1, 8'hA5);
    for (int i = 1; i <= 41; i++) begin
      step(1'b0, 8'h00);
      if (i == 1) chk("t2_empty", 32'(empty), 32'd1);
      if (i >= 1 && i <= 37 && ((i - 1) % CPB) == 0)
        chk("t2_bit", 32'(tx), 32'(pat[(i-1)/CPB]));
      if (i == 40) chk("t2_busy_last", 32'(busy), 32'd1);
      if (i == 41) chk("t2_busy_drop", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00);

    // 3: two back-to-back frames
    busy_cycles = 0;
    step(1'b1, 8'h55);
    busy_cycles += int'(busy);
    step(1'b1, 8'h0F);
    busy_cycles += int'(busy);
    for (int i = 0; i < 88; i++) begin
      step(1'b0, 8'h00);
      busy_cycles += int'(busy);
    end
    chk("t3_busy_cycles", 32'(busy_cycles), 32'd80);

    // 4: six consecutive pushes, sixth dropped
    peak = 0; ovf_pulses = 0; full_seen = 0;
    for (int i = 0; i < 6 + 5 * FRAME + 10; i++) begin
      step(i < 6, 8'($urandom));
      if (int'(count) > peak) peak = int'(count);
      ovf_pulses += int'(overflow);
      full_seen  += int'(full);
    end
    chk("t4_peak_count", 32'(peak), 32'd4);
    chk("t4_overflow_pulses", 32'(ovf_pulses), 32'd1);
    chk("t4_full_seen", 32'(full_seen > 0), 32'd1);
    chk("t4_drained", 32'(empty), 32'd1);

    // 5: reset asserted during data bit 3 with two bytes queued
    step(1'b1, 8'hF0);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00);
    chk("t5_pre_tx_low", 32'(tx), 32'd0);
    chk("t5_pre_count", 32'(count), 32'd2);
    hold_reset(2);
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00);

    // 6: push while full at the same edge the serialiser pops
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
    chk("t6_full", 32'(full), 32'd1);
    for (int i = 0; i < 36; i++) step(1'b0, 8'h00);
    step(1'b1, 8'hEE);
    chk("t6_count", 32'(count), 32'd3);
    chk("t6_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 200; i++) step(1'b0, 8'h00);

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) step($urandom_range(0, 3) == 0, 8'($urandom));
    for (int i = 0; i < 250; i++) step(1'b0, 8'h00);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
